// File: rtl/ccip_tx_skid_buf.sv
// Tx request skid buffer for one sub-AFU: per-channel FIFOs absorb requests issued
// after upstream almost-full, and drain only while downstream almost-full is low.

module ccip_tx_skid_fifo #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_SLACK = 4,
  parameter int unsigned W        = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         stall,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         alm_full,
  output logic         ovf
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - AF_SLACK);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             ovf_q, ovf_d;
  logic             pop, push_ok;

  always_comb begin
    pop         = (count_q != '0) && !stall;
    // A push into a full FIFO is still accepted when the head leaves the same cycle.
    push_ok     = push && ((count_q != FULL_CNT) || pop);
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    out_valid_d = pop;
    out_data_d  = out_data_q;
    ovf_d       = ovf_q;
    if (pop) begin
      out_data_d = mem_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (push && !push_ok) begin
      ovf_d = 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign alm_full  = (count_q >= AF_CNT);
  assign ovf       = ovf_q;
endmodule

module ccip_tx_skid_buf #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_SLACK = 4,
  parameter int unsigned C0_HDR_W = 74,
  parameter int unsigned C1_HDR_W = 80,
  parameter int unsigned DATA_W   = 512
) (
  input  logic                pClk,
  input  logic                SoftReset_n,
  input  logic                afu_c0_valid,
  input  logic [C0_HDR_W-1:0] afu_c0_hdr,
  input  logic                afu_c1_valid,
  input  logic [C1_HDR_W-1:0] afu_c1_hdr,
  input  logic [DATA_W-1:0]   afu_c1_data,
  input  logic                afu_c2_valid,
  input  logic [8:0]          afu_c2_hdr,
  input  logic [63:0]         afu_c2_data,
  output logic                afu_c0_almFull,
  output logic                afu_c1_almFull,
  output logic                mux_c0_valid,
  output logic [C0_HDR_W-1:0] mux_c0_hdr,
  output logic                mux_c1_valid,
  output logic [C1_HDR_W-1:0] mux_c1_hdr,
  output logic [DATA_W-1:0]   mux_c1_data,
  output logic                mux_c2_valid,
  output logic [8:0]          mux_c2_hdr,
  output logic [63:0]         mux_c2_data,
  input  logic                mux_c0_almFull,
  input  logic                mux_c1_almFull,
  output logic                ovf_c0,
  output logic                ovf_c1
);
  localparam int unsigned C1_W = C1_HDR_W + DATA_W;

  logic [C1_W-1:0] c1_out;
  logic            c2_valid_q, c2_valid_d;
  logic [8:0]      c2_hdr_q, c2_hdr_d;
  logic [63:0]     c2_data_q, c2_data_d;

  ccip_tx_skid_fifo #(
    .DEPTH    (DEPTH),
    .AF_SLACK (AF_SLACK),
    .W        (C0_HDR_W)
  ) u_c0 (
    .clk       (pClk),
    .rst_n     (SoftReset_n),
    .push      (afu_c0_valid),
    .push_data (afu_c0_hdr),
    .stall     (mux_c0_almFull),
    .out_valid (mux_c0_valid),
    .out_data  (mux_c0_hdr),
    .alm_full  (afu_c0_almFull),
    .ovf       (ovf_c0)
  );

  // Header and data share one FIFO entry so they can never separate.
  ccip_tx_skid_fifo #(
    .DEPTH    (DEPTH),
    .AF_SLACK (AF_SLACK),
    .W        (C1_W)
  ) u_c1 (
    .clk       (pClk),
    .rst_n     (SoftReset_n),
    .push      (afu_c1_valid),
    .push_data ({afu_c1_hdr, afu_c1_data}),
    .stall     (mux_c1_almFull),
    .out_valid (mux_c1_valid),
    .out_data  (c1_out),
    .alm_full  (afu_c1_almFull),
    .ovf       (ovf_c1)
  );

  assign mux_c1_hdr  = c1_out[C1_W-1:DATA_W];
  assign mux_c1_data = c1_out[DATA_W-1:0];

  always_comb begin
    c2_valid_d = afu_c2_valid;
    c2_hdr_d   = afu_c2_hdr;
    c2_data_d  = afu_c2_data;
  end

  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      c2_valid_q <= 1'b0;
      c2_hdr_q   <= '0;
      c2_data_q  <= '0;
    end else begin
      c2_valid_q <= c2_valid_d;
      c2_hdr_q   <= c2_hdr_d;
      c2_data_q  <= c2_data_d;
    end
  end

  assign mux_c2_valid = c2_valid_q;
  assign mux_c2_hdr   = c2_hdr_q;
  assign mux_c2_data  = c2_data_q;
endmodule
